// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit and the ALU it drives:
// ALU operation codes, RV32I opcodes, FSM state codes and mux select codes.
package multicycle_control_unit_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_LUI  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_SLL  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_AND  = 4'b0110,
      ALU_XOR  = 4'b0111,
      ALU_BEQ  = 4'b1000,
      ALU_BNE  = 4'b1001,
      ALU_BLT  = 4'b1010,
      ALU_SW   = 4'b1011,
      ALU_LW   = 4'b1100,
      ALU_JAL  = 4'b1101,
      ALU_JALR = 4'b1110
   } alu_op_t;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_MEM     = 3'd3,
      ST_WB      = 3'd4,
      ST_ILLEGAL = 3'd7
   } state_t;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_IALU   = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [1:0] SRC_A_PC     = 2'd0;
   localparam logic [1:0] SRC_A_RS1    = 2'd1;
   localparam logic [1:0] SRC_A_OLD_PC = 2'd2;

   localparam logic [1:0] SRC_B_RS2  = 2'd0;
   localparam logic [1:0] SRC_B_IMM  = 2'd1;
   localparam logic [1:0] SRC_B_FOUR = 2'd2;

   localparam logic PC_SRC_ALU    = 1'b0;
   localparam logic PC_SRC_ALUOUT = 1'b1;

   localparam logic [1:0] WB_SEL_ALUOUT = 2'd0;
   localparam logic [1:0] WB_SEL_MDR    = 2'd1;
   localparam logic [1:0] WB_SEL_PC     = 2'd2;

   // Loads are the only instructions that read memory after EXECUTE and
   // write the memory data register back.
   function automatic logic is_load(input logic [31:0] instr);
      return instr[6:0] == OPC_LOAD;
   endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle between the control unit (master) and the datapath/memory/ALU side
// (slave). Signal suffixes are relative to the control unit.
interface multicycle_control_unit_if #(
   parameter int RETIRE_CNT_WIDTH = 32
);
   logic [31:0]                 instr_i;
   logic                        mem_ready_i;
   logic                        alu_zero_i;
   logic [3:0]                  alu_op_o;
   logic [1:0]                  alu_src_a_o;
   logic [1:0]                  alu_src_b_o;
   logic                        pc_write_o;
   logic                        pc_src_o;
   logic                        ir_write_o;
   logic                        iord_o;
   logic                        mem_read_o;
   logic                        mem_write_o;
   logic                        reg_write_o;
   logic [1:0]                  wb_sel_o;
   logic                        illegal_o;
   logic [2:0]                  state_o;
   logic [RETIRE_CNT_WIDTH-1:0] retired_o;

   modport master (
      input  instr_i, mem_ready_i, alu_zero_i,
      output alu_op_o, alu_src_a_o, alu_src_b_o, pc_write_o, pc_src_o,
             ir_write_o, iord_o, mem_read_o, mem_write_o, reg_write_o,
             wb_sel_o, illegal_o, state_o, retired_o
   );

   modport slave (
      output instr_i, mem_ready_i, alu_zero_i,
      input  alu_op_o, alu_src_a_o, alu_src_b_o, pc_write_o, pc_src_o,
             ir_write_o, iord_o, mem_read_o, mem_write_o, reg_write_o,
             wb_sel_o, illegal_o, state_o, retired_o
   );
endinterface

// File: rtl/multicycle_control_unit_alu_op_decoder.sv
// Combinational instruction-field decoder: maps opcode/funct3/funct7 to the
// ALU operation and flags unknown opcodes and unsupported funct encodings.
module alu_op_decoder
   import multicycle_control_unit_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output alu_op_t    alu_op,
   output logic       bad_opcode,
   output logic       bad_funct
);

   // Opcode-class decode; anything not recognised defaults to ADD and is flagged.
   always_comb begin
      alu_op     = ALU_ADD;
      bad_opcode = 1'b0;
      bad_funct  = 1'b0;
      case (opcode)
         OPC_RTYPE, OPC_IALU: begin
            case (funct3)
               3'b000:  alu_op = (opcode == OPC_RTYPE && funct7[5]) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_op = ALU_SLL;
               3'b100:  alu_op = ALU_XOR;
               3'b101:  alu_op = ALU_SRL;
               3'b110:  alu_op = ALU_OR;
               3'b111:  alu_op = ALU_AND;
               default: bad_funct = 1'b1;
            endcase
            if (opcode == OPC_RTYPE) begin
               if (funct7 != 7'b0000000 && !(funct3 == 3'b000 && funct7 == 7'b0100000))
                  bad_funct = 1'b1;
            end else if (funct3 == 3'b101 && funct7 != 7'b0000000) begin
               bad_funct = 1'b1;
            end
         end
         OPC_LUI: alu_op = ALU_LUI;
         OPC_LOAD: begin
            alu_op = ALU_LW;
            if (funct3 != 3'b010) bad_funct = 1'b1;
         end
         OPC_STORE: begin
            alu_op = ALU_SW;
            if (funct3 != 3'b010) bad_funct = 1'b1;
         end
         OPC_BRANCH: begin
            case (funct3)
               3'b000:  alu_op = ALU_BEQ;
               3'b001:  alu_op = ALU_BNE;
               3'b100:  alu_op = ALU_BLT;
               default: bad_funct = 1'b1;
            endcase
         end
         OPC_JAL:  alu_op = ALU_JAL;
         OPC_JALR: alu_op = ALU_JALR;
         default:  bad_opcode = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB,
// drives the ALU and datapath mux controls and counts retired instructions.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int RETIRE_CNT_WIDTH = 32
) (
   input logic                        clk,
   input logic                        reset,
   multicycle_control_unit_if.master  bus
);

   state_t                      state;
   state_t                      state_n;
   logic                        retire;
   logic [RETIRE_CNT_WIDTH-1:0] retired_q;
   alu_op_t                     dec_op;
   logic                        dec_bad_opcode;
   logic                        dec_bad_funct;
   logic                        unused_instr_bits;

   // Register and immediate fields are consumed by the datapath, not here.
   assign unused_instr_bits = ^{bus.instr_i[24:15], bus.instr_i[11:7]};

   alu_op_decoder u_decoder (
      .opcode     (bus.instr_i[6:0]),
      .funct3     (bus.instr_i[14:12]),
      .funct7     (bus.instr_i[31:25]),
      .alu_op     (dec_op),
      .bad_opcode (dec_bad_opcode),
      .bad_funct  (dec_bad_funct)
   );

   // State register and retired-instruction counter (wraps naturally).
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_FETCH;
         retired_q <= '0;
      end else begin
         state <= state_n;
         if (retire) retired_q <= retired_q + RETIRE_CNT_WIDTH'(1);
      end
   end

   // Next-state and control outputs; reset overrides every enable last.
   always_comb begin
      state_n         = state;
      retire          = 1'b0;
      bus.alu_op_o    = ALU_ADD;
      bus.alu_src_a_o = SRC_A_PC;
      bus.alu_src_b_o = SRC_B_RS2;
      bus.pc_write_o  = 1'b0;
      bus.pc_src_o    = PC_SRC_ALU;
      bus.ir_write_o  = 1'b0;
      bus.iord_o      = 1'b0;
      bus.mem_read_o  = 1'b0;
      bus.mem_write_o = 1'b0;
      bus.reg_write_o = 1'b0;
      bus.wb_sel_o    = WB_SEL_ALUOUT;
      case (state)
         ST_FETCH: begin
            bus.mem_read_o  = 1'b1;
            bus.alu_src_b_o = SRC_B_FOUR;
            bus.ir_write_o  = bus.mem_ready_i;
            bus.pc_write_o  = bus.mem_ready_i;
            if (bus.mem_ready_i) state_n = ST_DECODE;
         end
         ST_DECODE: begin
            bus.alu_src_a_o = SRC_A_OLD_PC;
            bus.alu_src_b_o = SRC_B_IMM;
            state_n = dec_bad_opcode ? ST_ILLEGAL : ST_EXECUTE;
         end
         ST_EXECUTE: begin
            if (dec_bad_opcode || dec_bad_funct) begin
               state_n = ST_ILLEGAL;
            end else begin
               bus.alu_op_o = dec_op;
               case (bus.instr_i[6:0])
                  OPC_RTYPE: begin
                     bus.alu_src_a_o = SRC_A_RS1;
                     state_n = ST_WB;
                  end
                  OPC_IALU: begin
                     bus.alu_src_a_o = SRC_A_RS1;
                     bus.alu_src_b_o = SRC_B_IMM;
                     state_n = ST_WB;
                  end
                  OPC_LUI: begin
                     bus.alu_src_b_o = SRC_B_IMM;
                     state_n = ST_WB;
                  end
                  OPC_LOAD, OPC_STORE: begin
                     bus.alu_src_a_o = SRC_A_RS1;
                     bus.alu_src_b_o = SRC_B_IMM;
                     state_n = ST_MEM;
                  end
                  OPC_BRANCH: begin
                     bus.alu_src_a_o = SRC_A_RS1;
                     bus.pc_write_o  = bus.alu_zero_i;
                     bus.pc_src_o    = PC_SRC_ALUOUT;
                     retire  = 1'b1;
                     state_n = ST_FETCH;
                  end
                  OPC_JAL: begin
                     bus.pc_write_o  = 1'b1;
                     bus.pc_src_o    = PC_SRC_ALUOUT;
                     bus.reg_write_o = 1'b1;
                     bus.wb_sel_o    = WB_SEL_PC;
                     retire  = 1'b1;
                     state_n = ST_FETCH;
                  end
                  OPC_JALR: begin
                     bus.alu_src_a_o = SRC_A_RS1;
                     bus.alu_src_b_o = SRC_B_IMM;
                     bus.pc_write_o  = 1'b1;
                     bus.reg_write_o = 1'b1;
                     bus.wb_sel_o    = WB_SEL_PC;
                     retire  = 1'b1;
                     state_n = ST_FETCH;
                  end
                  default: state_n = ST_ILLEGAL;
               endcase
            end
         end
         ST_MEM: begin
            bus.iord_o      = 1'b1;
            bus.mem_read_o  = is_load(bus.instr_i);
            bus.mem_write_o = !is_load(bus.instr_i);
            if (bus.mem_ready_i) begin
               if (is_load(bus.instr_i)) begin
                  state_n = ST_WB;
               end else begin
                  retire  = 1'b1;
                  state_n = ST_FETCH;
               end
            end
         end
         ST_WB: begin
            bus.reg_write_o = 1'b1;
            bus.wb_sel_o    = is_load(bus.instr_i) ? WB_SEL_MDR : WB_SEL_ALUOUT;
            retire  = 1'b1;
            state_n = ST_FETCH;
         end
         ST_ILLEGAL: state_n = ST_ILLEGAL;
         default:    state_n = ST_FETCH;
      endcase
      if (reset) begin
         retire          = 1'b0;
         bus.pc_write_o  = 1'b0;
         bus.ir_write_o  = 1'b0;
         bus.mem_read_o  = 1'b0;
         bus.mem_write_o = 1'b0;
         bus.reg_write_o = 1'b0;
      end
   end

   assign bus.illegal_o = (state == ST_ILLEGAL);
   assign bus.state_o   = state;
   assign bus.retired_o = retired_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle RV32I control FSM. It is the initiator side of the ALU operation interface.
- Decodes the instruction register and sequences FETCH/DECODE/EXECUTE/MEM/WB.
- Drives the 4-bit ALU operation code and operand selects, and consumes the ALU zero flag for branch resolution.
- Sits between the instruction register, the datapath muxes, the shared memory port and the ALU.

Parameters:
- RETIRE_CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- instr_i  in  32  instruction register contents; stable from DECODE until the next FETCH completes.
- mem_ready_i  in  1  memory completes the current read/write this cycle.
- alu_zero_i  in  1  ALU zero flag (1 = branch condition true).
- alu_op_o  out  4  ALU operation code.
- alu_src_a_o  out  2  0=PC, 1=rs1, 2=oldPC.
- alu_src_b_o  out  2  0=rs2, 1=imm, 2=const 4.
- pc_write_o  out  1  PC load enable.
- pc_src_o  out  1  0=ALU result, 1=ALUOut register.
- ir_write_o  out  1  instruction register and oldPC load enable.
- iord_o  out  1  memory address: 0=PC, 1=ALUOut.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- reg_write_o  out  1  register file write enable.
- wb_sel_o  out  2  0=ALUOut, 1=memory data register, 2=PC.
- illegal_o  out  1  sticky illegal-instruction flag.
- state_o  out  3  current state code.
- retired_o  out  RETIRE_CNT_WIDTH  count of completed instructions.

Behaviour:
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, ILLEGAL=7.
- Outputs are combinational from the state and instr_i.
- Every enable not listed for a state is 0.
- Default alu_op is ADD.
- Reset:
  - The cycle after reset is sampled high: state=FETCH, retired_o=0, illegal_o=0.
  - While reset is high, all enables are forced to 0.
  - Reset mid-MEM aborts the access with no write; execution restarts at FETCH.
- FETCH:
  - mem_read_o=1, iord_o=0.
  - ALU computes PC+4 (src_a=0, src_b=2, ADD).
  - ir_write_o and pc_write_o (pc_src=0) equal mem_ready_i.
  - Stay in FETCH until mem_ready_i=1, then go to DECODE.
- DECODE:
  - ALU computes the branch/JAL target: src_a=2, src_b=1, ADD; the result is latched externally into ALUOut.
  - Legal opcode goes to EXECUTE; otherwise go to ILLEGAL.
- EXECUTE, by opcode class:
  - R-type (0110011): src_a=1, src_b=0.
    - funct3 000: ADD, or SUB when funct7[5]=1.
    - funct3 110=OR, 111=AND, 100=XOR, 001=SLL, 101=SRL.
    - Go to WB.
  - I-ALU (0010011): same mapping with src_b=1; funct7 is ignored except for 101 (SRL). Go to WB.
  - LUI (0110111): op LUI, src_b=1. Go to WB.
  - LW/SW (0000011/0100011): op LW/SW, src_a=1, src_b=1. Go to MEM.
  - Branch (1100011): src_a=1, src_b=0.
    - funct3 000=BEQ, 001=BNE, 100=BLT.
    - pc_write_o=alu_zero_i with pc_src=1.
    - Retire, then go to FETCH.
  - JAL (1101111): op JAL; pc_write_o=1, pc_src=1; reg_write_o=1, wb_sel=2. Retire, go to FETCH.
  - JALR (1100111): op JALR, src_a=1, src_b=1; pc_write_o=1, pc_src=0; reg_write_o=1, wb_sel=2. Retire, go to FETCH.
  - The register write uses the PC value before the PC update.
- Illegal encodings go to ILLEGAL instead of EXECUTE's normal action:
  - unknown funct3/funct7 combinations;
  - branch funct3 other than 000/001/100;
  - load/store funct3 other than 010.
- MEM:
  - iord_o=1; mem_read_o=1 for LW, mem_write_o=1 for SW.
  - Hold until mem_ready_i=1.
  - Then SW retires and goes to FETCH; LW goes to WB.
- WB:
  - reg_write_o=1; wb_sel=1 for LW, 0 otherwise.
  - Retire, then go to FETCH.
- ILLEGAL:
  - illegal_o=1; all enables 0.
  - Terminal until reset.
- Retire: retired_o increments by 1 on the retire cycle and wraps from all-ones to 0.

Decomposition:
- Shared package, also used by the ALU:
  - ALU op codes: ADD 0000, SUB 0001, LUI 0010, OR 0011, SLL 0100, SRL 0101, AND 0110, XOR 0111, BEQ 1000, BNE 1001, BLT 1010, SW 1011, LW 1100, JAL 1101, JALR 1110.
  - RV32I opcode constants.
  - State encodings.
  - Mux select encodings.
- One natural sub-module, alu_op_decoder: combinational mapping of opcode/funct3/funct7 to alu_op plus an illegal flag.

Test Plan:
- Reset held 2 cycles, then ADD 0x002081B3 with mem_ready_i=1 -> states 0,1,2,4,0; alu_op_o=0000 in EXECUTE; reg_write_o=1 in WB; retired_o=1.
- SUB 0x402081B3 -> EXECUTE alu_op_o=0001.
- BEQ 0x00208463 with alu_zero_i=1 -> EXECUTE alu_op_o=1000, pc_write_o=1, pc_src_o=1.
- Same BEQ with alu_zero_i=0 -> pc_write_o=0; back to FETCH; retired_o increments.
- LW 0x0000A283 with mem_ready_i low 3 cycles in MEM -> mem_read_o=1 and iord_o=1 held for 4 cycles; WB wb_sel_o=1.
- SW 0x0050A223 -> MEM mem_write_o=1, no WB state.
- Reset asserted in MEM -> mem_write_o=0 immediately and restart at FETCH.
- Instruction 0xFFFFFFFF -> ILLEGAL after DECODE; illegal_o=1 persists; no enables asserted.
- Preload retired_o to all-ones via forced retires, then ADD -> retired_o=0.
